usb_fs_line_tx: RTL and testbench

//   Full-speed USB (12 Mb/s) line transmitter for the DFU bootloader.
//   - Takes a packet as a byte stream (valid/ready, last flag).
//   - Emits SYNC, NRZI-encoded and bit-stuffed data, then EOP.
//   - Drives usb_p_tx/usb_n_tx/usb_tx_en into the pin-level SB_IO tristate wrapper.
//   - Transmit-direction counterpart of the line receiver in the DFU core.
//

---
 rtl/usb_fs_line_tx_pkg.sv | 31 +++
 rtl/usb_fs_bit_strobe.sv | 53 +++++
 rtl/usb_fs_line_tx.sv | 188 ++++++++++++++++++
 tb/tb_usb_fs_line_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb_fs_line_tx_pkg.sv
// Shared definitions for the full-speed USB line transmitter:
// line states, FSM encoding, SYNC pattern, stuffing threshold and the NRZI step.
package usb_fs_line_tx_pkg;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam logic [7:0] SYNC_PATTERN    = 8'h80;
    localparam logic [2:0] STUFF_THRESHOLD = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_DATA    = 3'd2,
        ST_EOP_SE0 = 3'd3,
        ST_EOP_J   = 3'd4
    } tx_state_e;

    // A 0 bit toggles J<->K, a 1 bit holds the current line state.
    function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic data_bit);
        logic [1:0] res;
        if (data_bit) begin
            res = line;
        end else begin
            res = (line == LINE_J) ? LINE_K : LINE_J;
        end
        return res;
    endfunction

endpackage

// File: rtl/usb_fs_bit_strobe.sv
// Bit-time divider: one-cycle strobe in the last clock of every bit time,
// plus a pre-strobe one clock earlier so callers can register outputs aligned to the strobe.
module usb_fs_bit_strobe #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic strobe,
    output logic pre_strobe
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_CNT  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          strobe_q;
    logic          pre_strobe_q;
    logic          run_s;

    // Next count: restart to zero at packet start, wrap every bit time while running.
    always_comb begin
        cnt_d = cnt_q;
        run_s = restart | enable;
        if (restart) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Counter and registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            strobe_q     <= 1'b0;
            pre_strobe_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            strobe_q     <= run_s & (cnt_d == LAST_CNT);
            pre_strobe_q <= run_s & (cnt_d == PRE_CNT);
        end
    end

    assign strobe     = strobe_q;
    assign pre_strobe = pre_strobe_q;

endmodule

// File: rtl/usb_fs_line_tx.sv
// Full-speed USB line transmitter: SYNC, NRZI with bit stuffing, then EOP,
// fed by a valid/ready byte stream with a one-cycle load slot per byte.
module usb_fs_line_tx
    import usb_fs_line_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_underrun,
    output logic       usb_p_tx,
    output logic       usb_n_tx,
    output logic       usb_tx_en
);

    tx_state_e  state_q, state_d;
    logic [1:0] line_q, line_d;
    logic       tx_en_q, tx_en_d;
    logic       busy_q, busy_d;
    logic       ready_q, ready_d;
    logic       underrun_q, underrun_d;
    logic [6:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] ones_q, ones_d;
    logic       last_q, last_d;
    logic       eop_cnt_q, eop_cnt_d;

    logic       start_s;
    logic       strobe_s;
    logic       pre_strobe_s;
    logic       byte_done_s;
    logic       slot_owed_s;

    usb_fs_bit_strobe #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_strobe (
        .clk        (clk_48mhz),
        .reset      (reset),
        .enable     (busy_q),
        .restart    (start_s),
        .strobe     (strobe_s),
        .pre_strobe (pre_strobe_s)
    );

    // Transmit FSM next-state: shift_q holds the not-yet-sent bits of the current byte,
    // bit_cnt_q the index of the data bit last put on the line.
    always_comb begin
        state_d     = state_q;
        line_d      = line_q;
        tx_en_d     = tx_en_q;
        busy_d      = busy_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        ones_d      = ones_q;
        last_d      = last_q;
        eop_cnt_d   = eop_cnt_q;
        ready_d     = 1'b0;
        underrun_d  = 1'b0;
        start_s     = 1'b0;
        byte_done_s = (bit_cnt_q == 3'd7) && (ones_q != STUFF_THRESHOLD);
        slot_owed_s = (state_q == ST_SYNC) || ((state_q == ST_DATA) && !last_q);

        case (state_q)
            ST_IDLE: begin
                line_d  = LINE_J;
                tx_en_d = 1'b0;
                busy_d  = 1'b0;
                if (tx_valid) begin
                    start_s   = 1'b1;
                    state_d   = ST_SYNC;
                    shift_d   = SYNC_PATTERN[7:1];
                    bit_cnt_d = 3'd0;
                    ones_d    = 3'd0;
                    last_d    = 1'b0;
                    line_d    = nrzi_next(LINE_J, SYNC_PATTERN[0]);
                    tx_en_d   = 1'b1;
                    busy_d    = 1'b1;
                end else begin
                    start_s = 1'b0;
                end
            end

            ST_SYNC, ST_DATA: begin
                if (strobe_s) begin
                    if (ones_q == STUFF_THRESHOLD) begin
                        // Stuff bit: toggle without advancing the shift register.
                        line_d = nrzi_next(line_q, 1'b0);
                        ones_d = 3'd0;
                    end else if (!byte_done_s) begin
                        shift_d   = {1'b0, shift_q[6:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        line_d    = nrzi_next(line_q, shift_q[0]);
                        ones_d    = shift_q[0] ? ones_q + 3'd1 : 3'd0;
                    end else if (ready_q && tx_valid) begin
                        state_d   = ST_DATA;
                        shift_d   = tx_data[7:1];
                        bit_cnt_d = 3'd0;
                        last_d    = tx_last;
                        line_d    = nrzi_next(line_q, tx_data[0]);
                        ones_d    = tx_data[0] ? ones_q + 3'd1 : 3'd0;
                    end else begin
                        state_d    = ST_EOP_SE0;
                        line_d     = LINE_SE0;
                        eop_cnt_d  = 1'b0;
                        underrun_d = slot_owed_s;
                    end
                end else if (pre_strobe_s) begin
                    ready_d = slot_owed_s && byte_done_s;
                end else begin
                    ready_d = 1'b0;
                end
            end

            ST_EOP_SE0: begin
                if (strobe_s) begin
                    if (eop_cnt_q) begin
                        state_d = ST_EOP_J;
                        line_d  = LINE_J;
                    end else begin
                        eop_cnt_d = 1'b1;
                    end
                end else begin
                    eop_cnt_d = eop_cnt_q;
                end
            end

            ST_EOP_J: begin
                if (strobe_s) begin
                    state_d = ST_IDLE;
                    line_d  = LINE_J;
                    tx_en_d = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_EOP_J;
                end
            end

            default: begin
                state_d = ST_IDLE;
                line_d  = LINE_J;
                tx_en_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any packet in flight.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            line_q     <= LINE_J;
            tx_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            underrun_q <= 1'b0;
            shift_q    <= 7'd0;
            bit_cnt_q  <= 3'd0;
            ones_q     <= 3'd0;
            last_q     <= 1'b0;
            eop_cnt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            tx_en_q    <= tx_en_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            ones_q     <= ones_d;
            last_q     <= last_d;
            eop_cnt_q  <= eop_cnt_d;
        end
    end

    assign usb_p_tx    = line_q[1];
    assign usb_n_tx    = line_q[0];
    assign usb_tx_en   = tx_en_q;
    assign tx_busy     = busy_q;
    assign tx_ready    = ready_q;
    assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_usb_fs_line_tx.sv
// Bench for usb_fs_line_tx: a bit-level packet model expands each packet into
// per-cycle expected outputs, checked every cycle, plus directed and random packets.
module tb_usb_fs_line_tx;

    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LSE0 = 2'b00;
    // {tx_en, busy, p, n, ready, underrun}
    localparam logic [5:0] IDLE_EXP = 6'b001000;

    logic       clk_48mhz = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_underrun;
    logic       usb_p_tx;
    logic       usb_n_tx;
    logic       usb_tx_en;

    int n_cmp = 0;
    int n_bad = 0;

    logic [5:0] exp_q [$];
    logic [1:0] m_lines [$];
    int         m_slots [$];
    logic [1:0] m_line;
    int         m_ones;
    logic [7:0] pkt [8];
    logic       s_en, s_busy, s_p, s_n, s_ready, s_und;

    usb_fs_line_tx #(.CLKS_PER_BIT(4)) dut (
        .clk_48mhz   (clk_48mhz),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .tx_underrun (tx_underrun),
        .usb_p_tx    (usb_p_tx),
        .usb_n_tx    (usb_n_tx),
        .usb_tx_en   (usb_tx_en)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // One clock: compare at the falling edge against the model queue, then step past the rising edge.
    task automatic tick();
        logic [5:0] e;
        logic [5:0] a;
        @(negedge clk_48mhz);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_EXP;
        a = {usb_tx_en, tx_busy, usb_p_tx, usb_n_tx, tx_ready, tx_underrun};
        {s_en, s_busy, s_p, s_n, s_ready, s_und} = a;
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL cycle_check t=%0t actual(en,busy,p,n,rdy,und)=%b required=%b", $time, a, e);
        end
        @(posedge clk_48mhz);
        #1;
    endtask

    task automatic model_bit(input logic b);
        if (!b) m_line = (m_line == LJ) ? LK : LJ;
        m_lines.push_back(m_line);
        m_ones = b ? m_ones + 1 : 0;
        if (m_ones == 6) begin
            m_line = (m_line == LJ) ? LK : LJ;
            m_lines.push_back(m_line);
            m_ones = 0;
        end
    endtask

    // Line state per bit time, and the bit index after which each load slot falls.
    task automatic build_model(input int nb, input bit und);
        logic [7:0] v;
        m_lines.delete();
        m_slots.delete();
        m_line = LJ;
        m_ones = 0;
        v = 8'h80;
        for (int i = 0; i < 8; i++) model_bit(v[i]);
        m_slots.push_back(m_lines.size() - 1);
        for (int k = 0; k < nb; k++) begin
            v = pkt[k];
            for (int i = 0; i < 8; i++) model_bit(v[i]);
            if (k < nb - 1 || und) m_slots.push_back(m_lines.size() - 1);
        end
        m_lines.push_back(LSE0);
        m_lines.push_back(LSE0);
        m_lines.push_back(LJ);
    endtask

    function automatic logic [5:0] model_entry(input int j, input bit und);
        int k;
        logic rdy, ur;
        k = (j - 1) / 4;
        rdy = 1'b0;
        foreach (m_slots[s]) if ((j % 4 == 0) && (m_slots[s] == k)) rdy = 1'b1;
        ur = und && ((j - 1) % 4 == 0) && (k >= 1) && (k - 1 == m_slots[m_slots.size() - 1]);
        return {1'b1, 1'b1, m_lines[k], rdy, ur};
    endfunction

    task automatic run_packet(input int nb, input bit und, input int abort_at,
                              output int busy_n, output int ready_n, output int und_n);
        int total, b;
        build_model(nb, und);
        total = 4 * m_lines.size();
        exp_q.push_back(IDLE_EXP);
        for (int j = 1; j <= total; j++) exp_q.push_back(model_entry(j, und));
        busy_n = 0; ready_n = 0; und_n = 0;
        for (int j = 0; j <= total; j++) begin
            if (abort_at != 0 && j == abort_at) begin
                while (exp_q.size() > 1) exp_q.delete(exp_q.size() - 1);
                reset = 1'b1;
                tx_valid = 1'b0;
                tick();
                reset = 1'b0;
                return;
            end
            b = 0;
            foreach (m_slots[s]) if (4 * (m_slots[s] + 1) < j) b++;
            if (b < nb) begin
                tx_valid = 1'b1;
                tx_data  = pkt[b];
                tx_last  = (b == nb - 1) && !und;
            end else begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
                tx_last  = 1'b0;
            end
            tick();
            if (s_busy)  busy_n++;
            if (s_ready) ready_n++;
            if (s_und)   und_n++;
        end
        tx_valid = 1'b0;
        tick();
        if (s_busy) busy_n++;
    endtask

    initial begin
        int bn, rn, un, bad;
        logic [1:0] t1 [19];
        t1 = '{LK, LJ, LK, LJ, LK, LJ, LK, LK, LK, LK, LJ, LK, LJ, LK, LK, LK, LSE0, LSE0, LJ};
        reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
        repeat (3) @(posedge clk_48mhz);
        #1;
        reset = 1'b0;
        tick();
        check("reset_state", {s_en, s_busy, s_p, s_n, s_ready, s_und}, 6'b001000);
        repeat (2) tick();

        pkt[0] = 8'hC3;
        run_packet(1, 1'b0, 0, bn, rn, un);
        bad = 0;
        for (int i = 0; i < 19; i++) if (m_lines.size() != 19 || m_lines[i] !== t1[i]) bad++;
        check("t1_model_lines", bad, 0);
        check("t1_busy_cycles", bn, 76);
        check("t1_ready_pulses", rn, 1);
        check("t1_underrun", un, 0);
        repeat (3) tick();

        pkt[0] = 8'hFF; pkt[1] = 8'h00;
        run_packet(2, 1'b0, 0, bn, rn, un);
        check("t2_stuff_line", m_lines[13], LJ);
        check("t2_busy_cycles", bn, 112);
        check("t2_ready_pulses", rn, 2);
        repeat (3) tick();

        pkt[0] = 8'hFC;
        run_packet(1, 1'b0, 0, bn, rn, un);
        check("t3_stuff_line", m_lines[16], LJ);
        check("t3_eop_line", m_lines[17], LSE0);
        check("t3_busy_cycles", bn, 80);
        repeat (3) tick();

        pkt[0] = 8'h55;
        run_packet(1, 1'b1, 0, bn, rn, un);
        check("t4_busy_cycles", bn, 76);
        check("t4_ready_pulses", rn, 2);
        check("t4_underrun_pulses", un, 1);
        repeat (3) tick();

        pkt[0] = 8'hC3;
        run_packet(1, 1'b0, 50, bn, rn, un);
        tick();
        check("t5_reset_mid_data", {s_en, s_p, s_n, s_busy}, 4'b0100);
        repeat (2) tick();
        run_packet(1, 1'b0, 0, bn, rn, un);
        check("t5_after_reset_busy", bn, 76);
        check("t5_after_reset_ready", rn, 1);
        repeat (2) tick();

        for (int p = 0; p < 30; p++) begin
            int nb;
            bit und;
            nb = $urandom_range(1, 4);
            und = ($urandom_range(0, 4) == 0);
            for (int k = 0; k < nb; k++) pkt[k] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
            run_packet(nb, und, 0, bn, rn, un);
            check("rand_underrun", un, und ? 1 : 0);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
